piece_ctrl: RTL and testbench

PIECE_CTRL -- requirements
Module: piece_ctrl

---
 rtl/tetris_pkg.sv | 49 ++++
 rtl/block_rotate.sv | 27 ++
 rtl/piece_ctrl.sv | 175 +++++++++++++++++
 tb/tb_piece_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry, shape codes, rotation one-hots and
// controller state encoding shared by the piece controller.
package tetris_pkg;

    localparam int ROW     = 20;
    localparam int COL     = 10;
    localparam int SPAWN_X = 4;
    localparam int SPAWN_Y = 1;

    localparam logic [2:0] SH_A = 3'd0;
    localparam logic [2:0] SH_B = 3'd1;
    localparam logic [2:0] SH_C = 3'd2;
    localparam logic [2:0] SH_D = 3'd3;
    localparam logic [2:0] SH_E = 3'd4;
    localparam logic [2:0] SH_F = 3'd5;
    localparam logic [2:0] SH_G = 3'd6;
    localparam logic [2:0] SH_X = 3'd7;

    localparam logic [3:0] ROT0 = 4'b1000;
    localparam logic [3:0] ROT1 = 4'b0100;
    localparam logic [3:0] ROT2 = 4'b0010;
    localparam logic [3:0] ROT3 = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SPAWN    = 3'd1,
        S_FALL     = 3'd2,
        S_PROBE    = 3'd3,
        S_LOCK     = 3'd4,
        S_WAIT_CLR = 3'd5,
        S_OVER     = 3'd6
    } state_e;

    // number of distinct rotations a shape cycles through
    function automatic logic [2:0] rot_span(input logic [2:0] shp);
        logic [2:0] n;
        case (shp)
            SH_D, SH_F, SH_G: n = 3'd2;
            SH_B, SH_C, SH_E: n = 3'd4;
            default:          n = 3'd1;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] norm_shape(input logic [2:0] shp);
        return (shp == SH_X) ? SH_A : shp;
    endfunction

endpackage

// File: rtl/block_rotate.sv
// block_rotate: combinational next-rotation of a 7-bit piece code.
module block_rotate
    import tetris_pkg::*;
(
    input  logic [6:0] blk_in,
    output logic [6:0] blk_out
);

    logic [2:0] shp;
    logic [3:0] rot;
    logic [3:0] rot_n;

    assign shp = blk_in[6:4];
    assign rot = blk_in[3:0];

    always_comb begin
        rot_n = rot;
        case (rot_span(shp))
            3'd2:    rot_n = (rot == ROT0) ? ROT1 : ROT0;
            3'd4:    rot_n = {rot[0], rot[3:1]};
            default: rot_n = rot;
        endcase
    end

    assign blk_out = {shp, rot_n};

endmodule

// File: rtl/piece_ctrl.sv
// piece_ctrl: active-piece controller; proposes placements to the board
// checker and commits, discards or locks them on its hit answer.
module piece_ctrl
    import tetris_pkg::*;
#(
    parameter int ROW     = tetris_pkg::ROW,
    parameter int COL     = tetris_pkg::COL,
    parameter int SPAWN_X = tetris_pkg::SPAWN_X,
    parameter int SPAWN_Y = tetris_pkg::SPAWN_Y
)(
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       tick,
    input  logic       mv_left,
    input  logic       mv_right,
    input  logic       mv_rot,
    input  logic       mv_down,
    input  logic [2:0] next_shape,
    input  logic       hit,
    input  logic       clear_done,
    output logic [6:0] BLOCK,
    output logic [3:0] x_pos,
    output logic [4:0] y_pos,
    output logic [6:0] probe_block,
    output logic [3:0] probe_x,
    output logic [4:0] probe_y,
    output logic       lock,
    output logic       game_over
);

    if ((COL > 16) || (ROW + 4 > 32)) begin : g_size_chk
        $error("board dimensions exceed position widths");
    end

    state_e     state_q, state_d;
    logic [6:0] blk_q, blk_d;
    logic [6:0] pb_q, pb_d;
    logic [3:0] x_q, x_d, px_q, px_d;
    logic [4:0] y_q, y_d, py_q, py_d;
    logic       down_q, down_d;
    logic [6:0] rot_blk;
    logic [6:0] spawn_blk;
    logic       acc_down, acc_rot, acc_left, acc_right;
    logic       show_probe;

    block_rotate u_rot (
        .blk_in  (blk_q),
        .blk_out (rot_blk)
    );

    assign spawn_blk = {norm_shape(next_shape), ROT0};

    // one accepted request per cycle, gravity and soft drop first
    assign acc_down  = tick | mv_down;
    assign acc_rot   = mv_rot & ~acc_down;
    assign acc_left  = mv_left & ~acc_down & ~mv_rot;
    assign acc_right = mv_right & ~acc_down & ~mv_rot & ~mv_left;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pb_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pb_q    <= pb_d;
            px_q    <= px_d;
            py_q    <= py_d;
            down_q  <= down_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        x_d     = x_q;
        y_d     = y_q;
        pb_d    = pb_q;
        px_d    = px_q;
        py_d    = py_q;
        down_d  = down_q;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_SPAWN;
                    pb_d    = spawn_blk;
                    px_d    = 4'(SPAWN_X);
                    py_d    = 5'(SPAWN_Y);
                end
            end
            S_SPAWN: begin
                if (hit) begin
                    state_d = S_OVER;
                    blk_d   = '0;
                end else begin
                    state_d = S_FALL;
                    blk_d   = pb_q;
                    x_d     = px_q;
                    y_d     = py_q;
                end
            end
            S_FALL: begin
                pb_d   = blk_q;
                px_d   = x_q;
                py_d   = y_q;
                down_d = 1'b0;
                unique case (1'b1)
                    acc_down: begin
                        py_d    = y_q + 5'd1;
                        down_d  = 1'b1;
                        state_d = S_PROBE;
                    end
                    acc_rot: begin
                        pb_d    = rot_blk;
                        state_d = S_PROBE;
                    end
                    acc_left: begin
                        px_d    = x_q - 4'd1;
                        state_d = S_PROBE;
                    end
                    acc_right: begin
                        px_d    = x_q + 4'd1;
                        state_d = S_PROBE;
                    end
                    default: ;
                endcase
            end
            S_PROBE: begin
                if (!hit) begin
                    state_d = S_FALL;
                    blk_d   = pb_q;
                    x_d     = px_q;
                    y_d     = py_q;
                end else if (down_q) begin
                    state_d = S_LOCK;
                end else begin
                    state_d = S_FALL;
                end
            end
            S_LOCK: begin
                state_d = S_WAIT_CLR;
                blk_d   = '0;
            end
            S_WAIT_CLR: begin
                if (clear_done) begin
                    state_d = S_SPAWN;
                    pb_d    = spawn_blk;
                    px_d    = 4'(SPAWN_X);
                    py_d    = 5'(SPAWN_Y);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign show_probe  = (state_q == S_SPAWN) || (state_q == S_PROBE);
    assign BLOCK       = blk_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign probe_block = show_probe ? pb_q : blk_q;
    assign probe_x     = show_probe ? px_q : x_q;
    assign probe_y     = show_probe ? py_q : y_q;
    assign lock        = (state_q == S_LOCK);
    assign game_over   = (state_q == S_OVER);

endmodule

// File: tb/tb_piece_ctrl.sv
// tb_piece_ctrl: vector table, directed corner sequences and a random
// run against a move-level model of the piece controller.
module tb_piece_ctrl;

    logic       clk = 1'b0;
    logic       clr, start, tick, mv_left, mv_right, mv_rot, mv_down;
    logic [2:0] next_shape;
    logic       hit, clear_done;
    logic [6:0] BLOCK, probe_block;
    logic [3:0] x_pos, probe_x;
    logic [4:0] y_pos, probe_y;
    logic       lock, game_over;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    piece_ctrl #(.ROW(20), .COL(10), .SPAWN_X(4), .SPAWN_Y(1)) dut (
        .clk(clk), .clr(clr), .start(start), .tick(tick),
        .mv_left(mv_left), .mv_right(mv_right), .mv_rot(mv_rot),
        .mv_down(mv_down), .next_shape(next_shape), .hit(hit),
        .clear_done(clear_done), .BLOCK(BLOCK), .x_pos(x_pos),
        .y_pos(y_pos), .probe_block(probe_block), .probe_x(probe_x),
        .probe_y(probe_y), .lock(lock), .game_over(game_over)
    );

    typedef enum {M_IDLE, M_FALL, M_WAIT, M_OVER} mode_t;
    mode_t mode;
    int    m_shape, m_ri, m_x, m_y;

    typedef struct {
        logic [4:0] p;
        logic       h;
        int         dx;
        int         dy;
        bit         rot;
        bit         lk;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int spans(input int s);
        case (s)
            0:       return 1;
            3, 5, 6: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [6:0] mk_blk(input int s, input int ri);
        logic [3:0] r;
        r = 4'b1000 >> ri;
        return {s[2:0], r};
    endfunction

    task automatic drive(input logic [4:0] p);
        {tick, mv_down, mv_rot, mv_left, mv_right} = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_piece(input string t);
        logic [6:0] eb;
        eb = mk_blk(m_shape, m_ri);
        chk({t, "_blk"}, BLOCK, eb);
        chk({t, "_x"}, x_pos, m_x);
        chk({t, "_y"}, y_pos, m_y);
        chk({t, "_pblk"}, probe_block, eb);
        chk({t, "_px"}, probe_x, m_x);
        chk({t, "_py"}, probe_y, m_y);
        chk({t, "_lock"}, lock, 0);
        chk({t, "_go"}, game_over, 0);
    endtask

    // p bits: tick, down, rot, left, right
    task automatic do_req(input logic [4:0] p, input logic h,
                          input logic [4:0] noise, output bit locked);
        int k, cri, cx, cy;
        locked = 0;
        if (p[4] | p[3])  k = 1;
        else if (p[2])    k = 2;
        else if (p[1])    k = 3;
        else if (p[0])    k = 4;
        else              k = 0;
        cri = m_ri;
        cx  = m_x;
        cy  = m_y;
        case (k)
            1: cy  = (m_y + 1) % 32;
            2: cri = (m_ri + 1) % spans(m_shape);
            3: cx  = (m_x + 15) % 16;
            4: cx  = (m_x + 1) % 16;
            default: ;
        endcase
        drive(p);
        step();
        if (k == 0) begin
            drive(5'b0);
            check_piece("nop");
            return;
        end
        drive(noise);
        hit = h;
        chk("probe_blk", probe_block, mk_blk(m_shape, cri));
        chk("probe_x", probe_x, cx);
        chk("probe_y", probe_y, cy);
        chk("probe_hold_blk", BLOCK, mk_blk(m_shape, m_ri));
        chk("probe_hold_x", x_pos, m_x);
        chk("probe_lock", lock, 0);
        step();
        hit = 1'b0;
        drive(5'b0);
        if (!h) begin
            m_ri = cri;
            m_x  = cx;
            m_y  = cy;
            check_piece("moved");
        end else if (k == 1) begin
            locked = 1;
            chk("lock_pulse", lock, 1);
            chk("lock_blk", BLOCK, mk_blk(m_shape, m_ri));
            chk("lock_x", x_pos, m_x);
            chk("lock_y", y_pos, m_y);
            step();
            chk("lock_end", lock, 0);
            chk("wait_blk", BLOCK, 0);
            mode = M_WAIT;
        end else begin
            check_piece("blocked");
        end
    endtask

    task automatic spawn(input logic [2:0] ns, input logic h,
                         input bit via_start);
        int es;
        es = (ns == 3'd7) ? 0 : int'(ns);
        next_shape = ns;
        if (via_start) start = 1'b1;
        else           clear_done = 1'b1;
        step();
        start      = 1'b0;
        clear_done = 1'b0;
        drive(5'($urandom_range(0, 31)));
        hit = h;
        chk("spawn_pblk", probe_block, mk_blk(es, 0));
        chk("spawn_px", probe_x, 4);
        chk("spawn_py", probe_y, 1);
        chk("spawn_blk", BLOCK, 0);
        chk("spawn_lock", lock, 0);
        step();
        hit = 1'b0;
        drive(5'b0);
        if (h) begin
            mode = M_OVER;
            chk("over_go", game_over, 1);
            chk("over_blk", BLOCK, 0);
        end else begin
            mode    = M_FALL;
            m_shape = es;
            m_ri    = 0;
            m_x     = 4;
            m_y     = 1;
            check_piece("spawn");
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(5'($urandom_range(0, 31)));
            step();
            chk("quiet_blk", BLOCK, 0);
            chk("quiet_lock", lock, 0);
            chk("quiet_go", game_over, (mode == M_OVER) ? 1 : 0);
        end
        drive(5'b0);
    endtask

    task automatic check_zero(input string t);
        chk({t, "_blk"}, BLOCK, 0);
        chk({t, "_x"}, x_pos, 0);
        chk({t, "_y"}, y_pos, 0);
        chk({t, "_pblk"}, probe_block, 0);
        chk({t, "_px"}, probe_x, 0);
        chk({t, "_py"}, probe_y, 0);
        chk({t, "_lock"}, lock, 0);
        chk({t, "_go"}, game_over, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit         lk;
        int         bx, by, bri;
        logic [3:0] er;

        tbl[0]  = '{5'b10010, 1'b0,  0, 1, 0, 0};
        tbl[1]  = '{5'b01000, 1'b0,  0, 1, 0, 0};
        tbl[2]  = '{5'b00111, 1'b0,  0, 0, 1, 0};
        tbl[3]  = '{5'b00011, 1'b0, -1, 0, 0, 0};
        tbl[4]  = '{5'b00001, 1'b0,  1, 0, 0, 0};
        tbl[5]  = '{5'b00100, 1'b1,  0, 0, 0, 0};
        tbl[6]  = '{5'b00010, 1'b1,  0, 0, 0, 0};
        tbl[7]  = '{5'b01100, 1'b0,  0, 1, 0, 0};
        tbl[8]  = '{5'b00000, 1'b0,  0, 0, 0, 0};
        tbl[9]  = '{5'b11111, 1'b1,  0, 0, 0, 1};
        tbl[10] = '{5'b00001, 1'b1,  0, 0, 0, 0};
        tbl[11] = '{5'b10000, 1'b1,  0, 0, 0, 1};

        clr = 1'b1;
        start = 1'b0;
        clear_done = 1'b0;
        hit = 1'b0;
        next_shape = 3'd0;
        drive(5'b0);
        mode = M_IDLE;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        clr = 1'b0;
        idle_cycles(2);
        check_zero("idle");

        // first spawn of shape A
        spawn(3'd0, 1'b0, 1);
        chk("r035_blk", BLOCK, 7'b0001000);
        chk("r035_x", x_pos, 4);
        chk("r035_y", y_pos, 1);

        // shape B rotated to 0001 then wrapping back to 1000
        do_req(5'b10000, 1'b1, 5'b0, lk);
        idle_cycles(1);
        spawn(3'd1, 1'b0, 0);
        for (int i = 0; i < 3; i++) do_req(5'b00100, 1'b0, 5'b0, lk);
        chk("r036_pre", BLOCK, 7'b0010001);
        do_req(5'b00100, 1'b0, 5'b0, lk);
        chk("r036_blk", BLOCK, 7'b0011000);

        // tick beats a same-cycle left
        do_req(5'b10010, 1'b0, 5'b0, lk);
        chk("r037_x", x_pos, 4);
        chk("r037_y", y_pos, 2);

        for (int i = 0; i < 12; i++) begin
            if (mode != M_FALL) begin
                idle_cycles(1);
                spawn(3'd1, 1'b0, 0);
            end
            bx  = m_x;
            by  = m_y;
            bri = m_ri;
            do_req(tbl[i].p, tbl[i].h, 5'($urandom_range(0, 31)), lk);
            chk($sformatf("tbl%0d_lock", i), lk, tbl[i].lk);
            if (!tbl[i].lk) begin
                er = tbl[i].rot ? 4'(4'b1000 >> ((bri + 1) % 4))
                                : 4'(4'b1000 >> bri);
                chk($sformatf("tbl%0d_x", i), x_pos, 4'(bx + tbl[i].dx));
                chk($sformatf("tbl%0d_y", i), y_pos, 5'(by + tbl[i].dy));
                chk($sformatf("tbl%0d_rot", i), BLOCK[3:0], er);
            end
        end

        // x wraps at the left edge without clamping
        idle_cycles(1);
        spawn(3'd2, 1'b0, 0);
        for (int i = 0; i < 5; i++) do_req(5'b00010, 1'b0, 5'b0, lk);
        chk("wrap_x", x_pos, 15);

        // drop to row 22 and lock there, then respawn
        while (m_y < 22) do_req(5'b01000, 1'b0, 5'b0, lk);
        chk("r038_y", y_pos, 22);
        do_req(5'b10000, 1'b1, 5'b0, lk);
        chk("r038_lock", lk, 1);
        idle_cycles(2);
        spawn(3'd3, 1'b0, 0);
        chk("r038_rx", x_pos, 4);
        chk("r038_ry", y_pos, 1);

        // blocked spawn ends the game until start
        do_req(5'b10000, 1'b1, 5'b0, lk);
        idle_cycles(1);
        spawn(3'd2, 1'b1, 0);
        idle_cycles(3);
        chk("r039_go", game_over, 1);
        spawn(3'd7, 1'b0, 1);
        chk("r039_shape7", BLOCK, 7'b0001000);

        // reset in the middle of a probe
        drive(5'b10000);
        step();
        drive(5'b0);
        clr = 1'b1;
        #1;
        check_zero("r040");
        clr  = 1'b0;
        mode = M_IDLE;
        clear_done = 1'b1;
        idle_cycles(3);
        clear_done = 1'b0;
        check_zero("r040_idle");

        // reset during the lock pulse
        spawn(3'd4, 1'b0, 1);
        drive(5'b10000);
        step();
        drive(5'b0);
        hit = 1'b1;
        step();
        hit = 1'b0;
        chk("clr_lock_pre", lock, 1);
        clr = 1'b1;
        #1;
        check_zero("clr_lock");
        clr  = 1'b0;
        mode = M_IDLE;
        idle_cycles(3);

        for (int n = 0; n < 400; n++) begin
            case (mode)
                M_FALL: do_req(5'($urandom_range(0, 31)),
                               1'($urandom_range(0, 3) == 0),
                               5'($urandom_range(0, 31)), lk);
                M_WAIT: begin
                    idle_cycles($urandom_range(0, 2));
                    spawn(3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 9) == 0), 0);
                end
                M_OVER: begin
                    idle_cycles(1);
                    spawn(3'($urandom_range(0, 7)), 1'b0, 1);
                end
                default: spawn(3'($urandom_range(0, 7)), 1'b0, 1);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
